// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store unit sitting between the pipeline and a simple request/ack
//   memory port. It accepts one aligned, legal access at a time, stalls the
//   pipeline while it is in flight, lane-selects and extends load data, and
//   replicates store data across all lanes with matching byte enables.
//   Misaligned or illegal requests raise a one-cycle exception pulse instead.
//
// Parameters
//   DW  data path width (32 or 64)
//   AW  address width (at least 3)
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req_valid/write/op/addr/wdata   pipeline access request
//   busy                     stall while an access is in flight
//   rsp_valid, rsp_rdata     one-cycle completion pulse and load result
//   exc_adel/ades/op         misaligned load / misaligned store / illegal op
//   mem_req/we/addr/be/wdata memory request side
//   mem_ack, mem_rdata       memory acknowledge and read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_write,
   input  logic [2:0]      req_op,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            busy,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            exc_adel,
   output logic            exc_ades,
   output logic            exc_op,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW/8-1:0] mem_be,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [2:0] OP_WORD   = 3'b000;
   localparam logic [2:0] OP_BYTE_S = 3'b001;
   localparam logic [2:0] OP_HALF_S = 3'b010;
   localparam logic [2:0] OP_BYTE_U = 3'b011;
   localparam logic [2:0] OP_HALF_U = 3'b100;
   localparam logic [2:0] OP_DWORD  = 3'b101;

   logic [1:0]    state;
   logic [1:0]    stateNext;
   logic          writeReg;
   logic [2:0]    opReg;
   logic [OW-1:0] offsetReg;
   logic          opLegal;
   logic          addrAligned;
   logic          accept;

   // Dword accesses only exist on a 64-bit data path.
   function automatic logic opIsLegal(input logic [2:0] op);
      logic legal;
      case (op)
         OP_WORD, OP_BYTE_S, OP_HALF_S,
         OP_BYTE_U, OP_HALF_U: legal = 1'b1;
         OP_DWORD:             legal = (DW == 64);
         default:              legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic isAligned(input logic [2:0] op, input logic [2:0] a);
      logic ok;
      case (op)
         OP_BYTE_S, OP_BYTE_U: ok = 1'b1;
         OP_HALF_S, OP_HALF_U: ok = (a[0] == 1'b0);
         OP_WORD:              ok = (a[1:0] == 2'b00);
         OP_DWORD:             ok = (a == 3'b000);
         default:              ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [NB-1:0] byteEnables(input logic [2:0] op,
                                                 input logic [OW-1:0] off);
      logic [NB-1:0] base;
      base = '0;
      case (op)
         OP_BYTE_S, OP_BYTE_U: base[0]   = 1'b1;
         OP_HALF_S, OP_HALF_U: base[1:0] = 2'b11;
         OP_WORD:              base[3:0] = 4'hF;
         OP_DWORD:             base      = '1;
         default:              base      = '0;
      endcase
      return base << off;
   endfunction

   function automatic logic [DW-1:0] replicate(input logic [2:0] op,
                                               input logic [DW-1:0] w);
      logic [DW-1:0] r;
      case (op)
         OP_BYTE_S, OP_BYTE_U: r = {NB{w[7:0]}};
         OP_HALF_S, OP_HALF_U: r = {(NB/2){w[15:0]}};
         OP_WORD:              r = {(NB/4){w[31:0]}};
         default:              r = w;
      endcase
      return r;
   endfunction

   // Shift the addressed lane down to bit 0, then fill the upper bits.
   // A word on a 64-bit path is sign-extended, like the other signed loads.
   function automatic logic [DW-1:0] extendLoad(input logic [DW-1:0] rd,
                                                input logic [2:0] op,
                                                input logic [OW-1:0] off);
      logic [DW-1:0] lane;
      logic [DW-1:0] r;
      lane = rd >> {off, 3'b000};
      case (op)
         OP_BYTE_S: begin
            r = {DW{lane[7]}};
            r[7:0] = lane[7:0];
         end
         OP_BYTE_U: begin
            r = '0;
            r[7:0] = lane[7:0];
         end
         OP_HALF_S: begin
            r = {DW{lane[15]}};
            r[15:0] = lane[15:0];
         end
         OP_HALF_U: begin
            r = '0;
            r[15:0] = lane[15:0];
         end
         OP_WORD: begin
            r = {DW{lane[31]}};
            r[31:0] = lane[31:0];
         end
         OP_DWORD:  r = lane;
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Request qualification: only an idle unit takes aligned, legal requests.
   always_comb begin
      opLegal     = opIsLegal(req_op);
      addrAligned = isAligned(req_op, req_addr[2:0]);
      accept      = (state == IDLE) && req_valid && opLegal && addrAligned;
   end

   // Next-state logic for the IDLE -> REQ -> RESP handshake.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept) stateNext = REQ;
            else        stateNext = IDLE;
         end
         REQ: begin
            if (mem_ack) stateNext = RESP;
            else         stateNext = REQ;
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State, request latching and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         writeReg  <= 1'b0;
         opReg     <= 3'b000;
         offsetReg <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         exc_adel  <= 1'b0;
         exc_ades  <= 1'b0;
         exc_op    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= stateNext;
         busy      <= (stateNext != IDLE);
         rsp_valid <= 1'b0;
         exc_adel  <= 1'b0;
         exc_ades  <= 1'b0;
         exc_op    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  writeReg  <= req_write;
                  opReg     <= req_op;
                  offsetReg <= req_addr[OW-1:0];
                  mem_req   <= 1'b1;
                  mem_we    <= req_write;
                  mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                  mem_be    <= byteEnables(req_op, req_addr[OW-1:0]);
                  mem_wdata <= replicate(req_op, req_wdata);
               end else if (req_valid) begin
                  // An illegal op hides any alignment problem.
                  if (!opLegal)       exc_op   <= 1'b1;
                  else if (req_write) exc_ades <= 1'b1;
                  else                exc_adel <= 1'b1;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= writeReg ? '0 : extendLoad(mem_rdata, opReg, offsetReg);
               end
            end
            RESP: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               mem_be  <= '0;
            end
            default: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               mem_be  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit. A 32-bit instance runs a table of
//   single accesses (loads, stores, exceptions) plus hand-written delayed-ack
//   and reset-in-flight sequences; a 64-bit instance covers dword and wide
//   lane cases. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        reset;
   logic        req_valid, req_write;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        busy, rsp_valid, exc_adel, exc_ades, exc_op;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   // 64-bit instance signals
   logic        r64_valid, r64_write;
   logic [2:0]  r64_op;
   logic [31:0] r64_addr;
   logic [63:0] r64_wdata;
   logic        b64, v64, adel64, ades64, eop64;
   logic [63:0] rdata64;
   logic        mreq64, mwe64, mack64;
   logic [31:0] maddr64;
   logic [63:0] mwdata64, mrdata64;
   logic [7:0]  mbe64;

   mem_access_unit #(.DW(32), .AW(32)) u32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_op(exc_op),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   mem_access_unit #(.DW(64), .AW(32)) u64 (
      .clk(clk), .reset(reset),
      .req_valid(r64_valid), .req_write(r64_write), .req_op(r64_op),
      .req_addr(r64_addr), .req_wdata(r64_wdata),
      .busy(b64), .rsp_valid(v64), .rsp_rdata(rdata64),
      .exc_adel(adel64), .exc_ades(ades64), .exc_op(eop64),
      .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64),
      .mem_be(mbe64), .mem_wdata(mwdata64),
      .mem_ack(mack64), .mem_rdata(mrdata64)
   );

   typedef struct {
      logic        wr;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [2:0]  expExc;    // {adel, ades, op}; 0 = access goes through
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic [31:0] expAddr;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[13];
   int   nCompared = 0;
   int   nMismatched = 0;
   logic [31:0] lastRsp = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One access on the 32-bit instance with mem_ack in the first REQ cycle.
   task automatic runVec(input vec_t v);
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_op = v.op;
      req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata; mem_ack = 1'b0;
      @(negedge clk);                                  // cycle 1
      req_valid = 1'b0;
      if (v.expExc != 3'b000) begin
         check("exc_flags", {61'd0, exc_adel, exc_ades, exc_op}, {61'd0, v.expExc});
         check("exc_mem_req", {63'd0, mem_req}, 64'd0);
         check("exc_busy", {63'd0, busy}, 64'd0);
         @(negedge clk);
         check("exc_pulse_end", {61'd0, exc_adel, exc_ades, exc_op}, 64'd0);
         check("exc_rsp_hold", {32'd0, rsp_rdata}, {32'd0, lastRsp});
      end else begin
         check("mem_req", {63'd0, mem_req}, 64'd1);
         check("mem_we", {63'd0, mem_we}, {63'd0, v.wr});
         check("mem_addr", {32'd0, mem_addr}, {32'd0, v.expAddr});
         check("busy_req", {63'd0, busy}, 64'd1);
         if (v.wr) begin
            check("mem_be", {60'd0, mem_be}, {60'd0, v.expBe});
            check("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.expWdata});
         end
         mem_ack = 1'b1;
         @(negedge clk);                               // cycle 2
         mem_ack = 1'b0;
         check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, v.expRdata});
         check("mem_req_off", {63'd0, mem_req}, 64'd0);
         check("mem_be_off", {60'd0, mem_be}, 64'd0);
         lastRsp = v.expRdata;
         @(negedge clk);                               // cycle 3
         check("rsp_pulse_end", {63'd0, rsp_valid}, 64'd0);
         check("busy_done", {63'd0, busy}, 64'd0);
      end
   endtask

   // One accepted access on the 64-bit instance, ack in the first REQ cycle.
   task automatic run64(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [7:0] expBe, input logic [63:0] expWdata,
                        input logic [31:0] expAddr, input logic [63:0] expRdata);
      @(negedge clk);
      r64_valid = 1'b1; r64_write = wr; r64_op = op; r64_addr = addr;
      r64_wdata = wdata; mrdata64 = rdata; mack64 = 1'b0;
      @(negedge clk);
      r64_valid = 1'b0;
      check("w_mem_req", {63'd0, mreq64}, 64'd1);
      check("w_mem_we", {63'd0, mwe64}, {63'd0, wr});
      check("w_mem_addr", {32'd0, maddr64}, {32'd0, expAddr});
      if (wr) begin
         check("w_mem_be", {56'd0, mbe64}, {56'd0, expBe});
         check("w_mem_wdata", mwdata64, expWdata);
      end
      mack64 = 1'b1;
      @(negedge clk);
      mack64 = 1'b0;
      check("w_rsp_valid", {63'd0, v64}, 64'd1);
      check("w_rsp_rdata", rdata64, expRdata);
      @(negedge clk);
      check("w_busy_done", {63'd0, b64}, 64'd0);
   endtask

   int busyCnt, rspCnt, reqCnt;

   initial begin
      //           wr    op      addr          wdata         rdata         exc     be      expWdata      expAddr       expRdata
      vecs[0]  = '{1'b0, 3'b001, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3'b000, 4'h0, 32'h0,        32'h0000_1000, 32'hFFFF_FF80};
      vecs[1]  = '{1'b0, 3'b100, 32'h0000_2002, 32'h0,        32'h9ABC_0000, 3'b000, 4'h0, 32'h0,        32'h0000_2000, 32'h0000_9ABC};
      vecs[2]  = '{1'b0, 3'b011, 32'h0000_1001, 32'h0,        32'h0000_F200, 3'b000, 4'h0, 32'h0,        32'h0000_1000, 32'h0000_00F2};
      vecs[3]  = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'h8001_0000, 3'b000, 4'h0, 32'h0,        32'h0000_0000, 32'hFFFF_8001};
      vecs[4]  = '{1'b0, 3'b000, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 3'b000, 4'h0, 32'h0,        32'h0000_0010, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 3'b001, 32'h0000_0101, 32'h0000_00A5, 32'h1234_5678, 3'b000, 4'h2, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0};
      vecs[6]  = '{1'b1, 3'b100, 32'h0000_0202, 32'h0000_1234, 32'h1234_5678, 3'b000, 4'hC, 32'h1234_1234, 32'h0000_0200, 32'h0};
      vecs[7]  = '{1'b1, 3'b000, 32'h0000_0300, 32'hCAFE_F00D, 32'h1234_5678, 3'b000, 4'hF, 32'hCAFE_F00D, 32'h0000_0300, 32'h0};
      vecs[8]  = '{1'b0, 3'b011, 32'h0000_0007, 32'h0,        32'h5A00_0000, 3'b000, 4'h0, 32'h0,        32'h0000_0004, 32'h0000_005A};
      vecs[9]  = '{1'b0, 3'b000, 32'h0000_0002, 32'h0,        32'h0,         3'b100, 4'h0, 32'h0,        32'h0,         32'h0};
      vecs[10] = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h0,         3'b001, 4'h0, 32'h0,        32'h0,         32'h0};
      vecs[11] = '{1'b1, 3'b010, 32'h0000_0001, 32'h0,        32'h0,         3'b010, 4'h0, 32'h0,        32'h0,         32'h0};
      vecs[12] = '{1'b1, 3'b111, 32'h0000_0003, 32'h0,        32'h0,         3'b001, 4'h0, 32'h0,        32'h0,         32'h0};

      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_op = 3'b000; req_addr = 32'h0;
      req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      r64_valid = 1'b0; r64_write = 1'b0; r64_op = 3'b000; r64_addr = 32'h0;
      r64_wdata = 64'h0; mack64 = 1'b0; mrdata64 = 64'h0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("rst_mem", {29'd0, mem_req, mem_we, mem_be, mem_addr}, 64'd0);
      check("rst_exc", {61'd0, exc_adel, exc_ades, exc_op}, 64'd0);
      check("rst_wdata64", mwdata64, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) runVec(vecs[i]);

      // mem_ack arrives in the fifth REQ cycle: busy 6 cycles, mem_req 5
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_op = 3'b000;
      req_addr = 32'h0000_0040; mem_rdata = 32'h1357_2468;
      busyCnt = 0; rspCnt = 0; reqCnt = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         busyCnt += int'(busy);
         rspCnt  += int'(rsp_valid);
         reqCnt  += int'(mem_req);
         if (k == 6) check("dly_rsp_cycle", {63'd0, rsp_valid}, 64'd1);
         mem_ack = (k == 5);
      end
      check("dly_busy_cycles", 64'(busyCnt), 64'd6);
      check("dly_mem_req_cycles", 64'(reqCnt), 64'd5);
      check("dly_rsp_cycles", 64'(rspCnt), 64'd1);
      check("dly_rsp_rdata", {32'd0, rsp_rdata}, 64'h1357_2468);

      // Reset during REQ abandons the access; a late ack does nothing
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_op = 3'b000; req_addr = 32'h0000_0080;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      req_valid = 1'b0;
      check("rreq_mem_req", {63'd0, mem_req}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; mem_ack = 1'b1;
      rspCnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rspCnt += int'(rsp_valid);
      end
      mem_ack = 1'b0;
      check("rreq_no_rsp", 64'(rspCnt), 64'd0);
      check("rreq_busy", {63'd0, busy}, 64'd0);
      check("rreq_mem_req_off", {63'd0, mem_req}, 64'd0);
      lastRsp = 32'h0;
      runVec(vecs[0]);

      // 64-bit data path
      run64(1'b1, 3'b010, 32'h6, 64'hBEEF, 64'h0,
            8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 32'h0, 64'h0);
      run64(1'b0, 3'b101, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF,
            8'hFF, 64'h0, 32'h8, 64'h0123_4567_89AB_CDEF);
      run64(1'b0, 3'b001, 32'h15, 64'h0, 64'h0000_9C00_0000_0000,
            8'h20, 64'h0, 32'h10, 64'hFFFF_FFFF_FFFF_FF9C);
      run64(1'b0, 3'b000, 32'h24, 64'h0, 64'h8765_4321_0000_0000,
            8'hF0, 64'h0, 32'h20, 64'hFFFF_FFFF_8765_4321);

      // Misaligned dword load on the 64-bit path
      @(negedge clk);
      r64_valid = 1'b1; r64_write = 1'b0; r64_op = 3'b101; r64_addr = 32'h4;
      @(negedge clk);
      r64_valid = 1'b0;
      check("w_exc_adel", {61'd0, adel64, ades64, eop64}, 64'd4);
      check("w_exc_no_req", {63'd0, mreq64}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
